complement_sequencer: RTL and testbench

Bit-sliced 1's/2's complement engine built around a 3-bit complement datapath slice. It accepts a SLICES×3-bit word over a valid/ready handshake and processes it LSB slice first, one 3-bit slice per cycle. It propagates the +1 carry between slices and returns the complemented word, with an overflow flag, over a second valid/ready handshake. It sits between a word source and any consumer needing negation, and it time-shares one 3-bit complement slice across the full word width.

---
 rtl/complement_sequencer.sv | 122 ++++++++++++
 tb/tb_complement_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/complement_sequencer.sv
// Bit-sliced 1's/2's complement engine. One 3-bit complement slice is reused
// across the word, LSB slice first, with the +1 carry propagated between cycles.
module complement_sequencer #(
    parameter int unsigned SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*SLICES-1:0]   in_data,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3*SLICES-1:0]   out_data,
    output logic                  out_ovf,
    output logic                  busy
);

    localparam int unsigned W    = 3 * SLICES;
    localparam int unsigned IdxW = $clog2(SLICES);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(SLICES - 1);
    localparam logic [W-1:0]    MinNeg  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]    SliceMask = W'(3'b111);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    operand_q, operand_d;
    logic [W-1:0]    result_q, result_d;
    logic            mode_q, mode_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic [IdxW-1:0] idx_q, idx_d;

    logic [W-1:0]    operand_shifted;
    logic [2:0]      slice;
    logic [3:0]      sum;
    logic [31:0]     bit_pos;

    // Shared complement slice: select the current 3 bits and add the carry.
    always_comb begin
        bit_pos         = 32'(3 * idx_q);
        operand_shifted = operand_q >> bit_pos;
        slice           = operand_shifted[2:0];
        sum             = {1'b0, ~slice} + {3'b000, carry_q};
    end

    // Next-state logic for the sequencer and its datapath registers.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        result_d  = result_q;
        mode_d    = mode_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        idx_d     = idx_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    operand_d = in_data;
                    mode_d    = mode;
                    carry_d   = mode;
                    idx_d     = '0;
                    result_d  = '0;
                    ovf_d     = 1'b0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                result_d = (result_q & ~(SliceMask << bit_pos)) | (W'(sum[2:0]) << bit_pos);
                carry_d  = sum[3];
                if (idx_q == LastIdx) begin
                    // Final carry-out is dropped; overflow only for the most-negative input.
                    ovf_d   = mode_q && (operand_q == MinNeg);
                    idx_d   = '0;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            operand_q <= '0;
            result_q  <= '0;
            mode_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            mode_q    <= mode_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            idx_q     <= idx_d;
        end
    end

    // Handshake outputs depend on state only.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_data  = result_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_complement_sequencer.sv
// Scoreboard bench for complement_sequencer: stimulus pushes expected results,
// a negedge monitor pops and compares on each output handshake.
module tb_complement_sequencer;

    localparam int unsigned SLICES = 4;
    localparam int unsigned W      = 3 * SLICES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         mode = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;

    int unsigned  n_pass = 0;
    int unsigned  n_total = 0;
    int unsigned  cyc = 0;
    int unsigned  acc_cyc = 0;
    bit           seen_valid = 1'b0;
    logic [W:0]   exp_q[$];

    complement_sequencer #(.SLICES(SLICES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count rising edges so latency can be measured in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: latency on first out_valid, scoreboard compare on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!seen_valid) begin
                seen_valid = 1'b1;
                check("latency", cyc - acc_cyc, SLICES);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(out_data), 32'hDEAD);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[W-1:0]));
                    check("out_ovf", 32'(out_ovf), 32'(e[W]));
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] d, input logic m,
                        input logic [W-1:0] ed, input logic eo);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 32'd1);
            return;
        end
        in_valid   = 1'b1;
        in_data    = d;
        mode       = m;
        acc_cyc    = cyc + 1;
        seen_valid = 1'b0;
        exp_q.push_back({eo, ed});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #3;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_out_ovf", 32'(out_ovf), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, out_ready held high.
        send(12'h001, 1'b1, 12'hFFF, 1'b0); drain();
        send(12'h001, 1'b0, 12'hFFE, 1'b0); drain();
        send(12'h000, 1'b1, 12'h000, 1'b0); drain();
        send(12'h008, 1'b1, 12'hFF8, 1'b0); drain();
        send(12'h5A0, 1'b1, 12'hA60, 1'b0); drain();
        send(12'h800, 1'b1, 12'h800, 1'b1); drain();
        send(12'h800, 1'b0, 12'h7FF, 1'b0); drain();

        // Backpressure with input noise during RUN.
        out_ready = 1'b0;
        send(12'h3C5, 1'b1, 12'hC3B, 1'b0);
        for (int i = 0; i < int'(SLICES) - 1; i++) begin
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_data  = W'($urandom);
            mode     = ~mode;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_out_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_busy", 32'(busy), 1);
            check("bp_out_data", 32'(out_data), 32'hC3B);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        // Asynchronous reset during the second RUN cycle.
        send(12'h5A0, 1'b1, 12'hA60, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 1);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_out_data", 32'(out_data), 0);
        check("mid_rst_out_ovf", 32'(out_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SLICES + 2) @(negedge clk);
        send(12'h123, 1'b1, 12'hEDD, 1'b0); drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
